// File: rtl/pzbcm_sram_1rw_access_controller_pkg.sv
// Shared types and helpers for the 1RW SRAM access controller and its
// response buffer.
package pzbcm_sram_pkg;

    typedef enum logic {
        PZBCM_SRAM_WRITE = 1'b0,
        PZBCM_SRAM_READ  = 1'b1
    } pzbcm_sram_access_type;

    // Two spare entries beyond the read latency keep reads flowing back to back.
    function automatic int get_response_depth(input int read_latency);
        return read_latency + 2;
    endfunction

    function automatic int get_pointer_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/pzbcm_sram_1rw_access_controller_if.sv
// Client request/response and SRAM port bundle. Signal directions are named
// from the controller's point of view.
interface pzbcm_sram_1rw_access_controller_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int POINTER_WIDTH = 6
);
    logic                     i_write_valid;
    logic                     o_write_ready;
    logic [POINTER_WIDTH-1:0] i_write_pointer;
    logic [DATA_WIDTH-1:0]    i_write_data;
    logic                     i_read_valid;
    logic                     o_read_ready;
    logic [POINTER_WIDTH-1:0] i_read_pointer;
    logic                     o_response_valid;
    logic                     i_response_ready;
    logic [DATA_WIDTH-1:0]    o_response_data;
    logic                     o_sram_enable;
    logic                     o_sram_write;
    logic [POINTER_WIDTH-1:0] o_sram_pointer;
    logic [DATA_WIDTH-1:0]    o_sram_write_data;
    logic [DATA_WIDTH-1:0]    i_sram_read_data;

    modport master (
        input  i_write_valid, i_write_pointer, i_write_data,
        input  i_read_valid, i_read_pointer,
        input  i_response_ready, i_sram_read_data,
        output o_write_ready, o_read_ready,
        output o_response_valid, o_response_data,
        output o_sram_enable, o_sram_write, o_sram_pointer, o_sram_write_data
    );

    modport slave (
        output i_write_valid, i_write_pointer, i_write_data,
        output i_read_valid, i_read_pointer,
        output i_response_ready, i_sram_read_data,
        input  o_write_ready, o_read_ready,
        input  o_response_valid, o_response_data,
        input  o_sram_enable, o_sram_write, o_sram_pointer, o_sram_write_data
    );

endinterface

// File: rtl/pzbcm_sram_1rw_access_controller_fifo.sv
// In-order FIFO with register-array storage, used as the read response
// buffer. Flags can be registered (FLAG_FF_OUT=1) or decoded from the count.
module pzbcm_fifo #(
    parameter int  DEPTH         = 8,
    parameter int  DATA_WIDTH    = 32,
    parameter int  FLAG_FF_OUT   = 1,
    localparam int POINTER_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int COUNT_WIDTH   = $clog2(DEPTH + 1)
)(
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic [DATA_WIDTH-1:0]  i_data,
    input  logic                   i_pop,
    output logic [DATA_WIDTH-1:0]  o_data,
    output logic                   o_empty,
    output logic                   o_full,
    output logic [COUNT_WIDTH-1:0] o_count
);

    logic [DATA_WIDTH-1:0]    r_storage [DEPTH];
    logic [POINTER_WIDTH-1:0] r_write_pointer;
    logic [POINTER_WIDTH-1:0] r_read_pointer;
    logic [COUNT_WIDTH-1:0]   r_count;
    logic [COUNT_WIDTH-1:0]   w_count_next;
    logic                     w_pop;

    function automatic logic [POINTER_WIDTH-1:0] increment(input logic [POINTER_WIDTH-1:0] pointer);
        return (pointer == POINTER_WIDTH'(DEPTH - 1)) ? '0 : pointer + POINTER_WIDTH'(1);
    endfunction

    assign w_pop = i_pop && (r_count != '0);

    always_comb begin
        w_count_next = r_count;
        if (i_push && !w_pop) begin
            w_count_next = r_count + COUNT_WIDTH'(1);
        end else if (!i_push && w_pop) begin
            w_count_next = r_count - COUNT_WIDTH'(1);
        end
    end

    // Storage is cleared on reset so the output word reads as zero afterwards.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_storage[i] <= '0;
            end
            r_write_pointer <= '0;
            r_read_pointer  <= '0;
            r_count         <= '0;
        end else begin
            if (i_push) begin
                r_storage[r_write_pointer] <= i_data;
                r_write_pointer            <= increment(r_write_pointer);
            end
            if (w_pop) begin
                r_read_pointer <= increment(r_read_pointer);
            end
            r_count <= w_count_next;
        end
    end

    generate
        if (FLAG_FF_OUT != 0) begin : g_flag_ff
            logic r_empty;
            logic r_full;
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_empty <= 1'b1;
                    r_full  <= 1'b0;
                end else begin
                    r_empty <= (w_count_next == '0);
                    r_full  <= (w_count_next == COUNT_WIDTH'(DEPTH));
                end
            end
            assign o_empty = r_empty;
            assign o_full  = r_full;
        end else begin : g_flag_comb
            assign o_empty = (r_count == '0);
            assign o_full  = (r_count == COUNT_WIDTH'(DEPTH));
        end
    endgenerate

    assign o_data  = r_storage[r_read_pointer];
    assign o_count = r_count;

endmodule

// File: rtl/pzbcm_sram_1rw_access_controller.sv
// Initiator side of a 1RW SRAM port: arbitrates writes and reads onto the
// shared port and returns read data through a credit-protected FIFO.
module pzbcm_sram_1rw_access_controller
    import pzbcm_sram_pkg::*;
#(
    parameter int WORDS          = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int POINTER_WIDTH  = get_pointer_width(WORDS),
    parameter int READ_LATENCY   = 1,
    parameter int RESPONSE_DEPTH = get_response_depth(READ_LATENCY)
)(
    input logic                                i_clk,
    input logic                                i_rst,
    pzbcm_sram_1rw_access_controller_if.master io_bus
);

    localparam int INFLIGHT_WIDTH = $clog2(READ_LATENCY + 1);
    localparam int COUNT_WIDTH    = $clog2(RESPONSE_DEPTH + 1);

    pzbcm_sram_access_type     r_priority;
    logic [INFLIGHT_WIDTH-1:0] r_inflight;
    logic [READ_LATENCY-1:0]   r_read_pipe;

    logic                     w_read_credit;
    logic                     w_write_request;
    logic                     w_read_request;
    logic                     w_contended;
    logic                     w_write_grant;
    logic                     w_read_grant;
    logic                     w_read_exit;
    logic [POINTER_WIDTH-1:0] w_sram_pointer;
    logic [DATA_WIDTH-1:0]    w_push_data;
    logic                     w_response_pop;
    logic                     w_response_empty;
    logic                     w_response_full;
    logic [COUNT_WIDTH-1:0]   w_response_count;
    logic [DATA_WIDTH-1:0]    w_response_data;

    // A read is only issued when its response is guaranteed a buffer slot.
    assign w_read_credit   = (32'(r_inflight) + 32'(w_response_count)) < 32'(RESPONSE_DEPTH);
    assign w_write_request = io_bus.i_write_valid && !i_rst;
    assign w_read_request  = io_bus.i_read_valid && w_read_credit && !i_rst;
    assign w_contended     = w_write_request && w_read_request;
    assign w_write_grant   = w_write_request && (!w_read_request || (r_priority == PZBCM_SRAM_WRITE));
    assign w_read_grant    = w_read_request && (!w_write_request || (r_priority == PZBCM_SRAM_READ));

    always_comb begin
        w_sram_pointer = '0;
        if (w_write_grant) begin
            w_sram_pointer = io_bus.i_write_pointer;
        end else if (w_read_grant) begin
            w_sram_pointer = io_bus.i_read_pointer;
        end
    end

    assign io_bus.o_write_ready     = w_write_grant;
    assign io_bus.o_read_ready      = w_read_grant;
    assign io_bus.o_sram_enable     = w_write_grant || w_read_grant;
    assign io_bus.o_sram_write      = w_write_grant;
    assign io_bus.o_sram_pointer    = w_sram_pointer;
    assign io_bus.o_sram_write_data = w_write_grant ? io_bus.i_write_data : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_priority <= PZBCM_SRAM_WRITE;
        end else if (w_contended) begin
            r_priority <= w_write_grant ? PZBCM_SRAM_READ : PZBCM_SRAM_WRITE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_read_pipe <= '0;
        end else begin
            r_read_pipe[0] <= w_read_grant;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_read_pipe[i] <= r_read_pipe[i-1];
            end
        end
    end

    assign w_read_exit = r_read_pipe[READ_LATENCY-1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_inflight <= '0;
        end else begin
            case ({w_read_grant, w_read_exit})
                2'b10:   r_inflight <= r_inflight + INFLIGHT_WIDTH'(1);
                2'b01:   r_inflight <= r_inflight - INFLIGHT_WIDTH'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // SRAM read data is only looked at when the final pipeline stage is valid.
    assign w_push_data    = w_read_exit ? io_bus.i_sram_read_data : '0;
    assign w_response_pop = !w_response_empty && io_bus.i_response_ready;

    pzbcm_fifo #(
        .DEPTH       (RESPONSE_DEPTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .FLAG_FF_OUT (1)
    ) u_response_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_read_exit),
        .i_data  (w_push_data),
        .i_pop   (w_response_pop),
        .o_data  (w_response_data),
        .o_empty (w_response_empty),
        .o_full  (w_response_full),
        .o_count (w_response_count)
    );

    assign io_bus.o_response_valid = !w_response_empty;
    assign io_bus.o_response_data  = w_response_data;

    a_no_push_when_full: assert property (
        @(posedge i_clk) disable iff (i_rst) !(w_read_exit && w_response_full)
    );

    a_pointer_in_range: assert property (
        @(posedge i_clk) disable iff (i_rst) !io_bus.o_sram_enable || (32'(w_sram_pointer) < 32'(WORDS))
    );

endmodule

// File: tb/tb_pzbcm_sram_1rw_access_controller.sv
// Scoreboard bench for the 1RW SRAM access controller: a default instance
// (latency 1) and a latency-3 instance, each backed by a behavioural SRAM.
module tb_pzbcm_sram_1rw_access_controller;

    typedef struct {
        logic [31:0] data;
        int          grant_cycle;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pzbcm_sram_1rw_access_controller_if #(.DATA_WIDTH(32), .POINTER_WIDTH(6)) b0 ();
    pzbcm_sram_1rw_access_controller_if #(.DATA_WIDTH(32), .POINTER_WIDTH(6)) b1 ();

    pzbcm_sram_1rw_access_controller #(
        .WORDS(64), .DATA_WIDTH(32)
    ) u_dut0 (
        .i_clk(clk), .i_rst(rst), .io_bus(b0.master)
    );

    pzbcm_sram_1rw_access_controller #(
        .WORDS(64), .DATA_WIDTH(32), .READ_LATENCY(3), .RESPONSE_DEPTH(5)
    ) u_dut1 (
        .i_clk(clk), .i_rst(rst), .io_bus(b1.master)
    );

    // Behavioural SRAMs: one-cycle and three-cycle read latency.
    logic [31:0] sram0 [64];
    logic [31:0] sram0_q;
    always @(posedge clk) begin
        if (b0.o_sram_enable) begin
            if (b0.o_sram_write) sram0[b0.o_sram_pointer] <= b0.o_sram_write_data;
            else                 sram0_q <= sram0[b0.o_sram_pointer];
        end
    end
    assign b0.i_sram_read_data = sram0_q;

    logic [31:0] sram1 [64];
    logic [31:0] sram1_s1, sram1_s2, sram1_s3;
    always @(posedge clk) begin
        if (b1.o_sram_enable) begin
            if (b1.o_sram_write) sram1[b1.o_sram_pointer] <= b1.o_sram_write_data;
            else                 sram1_s1 <= sram1[b1.o_sram_pointer];
        end
        sram1_s2 <= sram1_s1;
        sram1_s3 <= sram1_s2;
    end
    assign b1.i_sram_read_data = sram1_s3;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          resp0 = 0;
    int          resp1 = 0;
    int          lat0 = -1;
    int          lat1 = -1;
    logic [31:0] ref0 [64];
    logic [31:0] ref1 [64];
    exp_t        q0[$];
    exp_t        q1[$];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic drive_idle();
        b0.i_write_valid = 1'b0; b0.i_write_pointer = '0; b0.i_write_data = '0;
        b0.i_read_valid  = 1'b0; b0.i_read_pointer  = '0; b0.i_response_ready = 1'b1;
        b1.i_write_valid = 1'b0; b1.i_write_pointer = '0; b1.i_write_data = '0;
        b1.i_read_valid  = 1'b0; b1.i_read_pointer  = '0; b1.i_response_ready = 1'b1;
    endtask

    // One clock: update the reference memories, push expected read data on a
    // grant, pop and compare on every consumed response, then move to the
    // next falling edge.
    task automatic cycle();
        exp_t e;
        #1;
        if (rst) begin
            q0.delete();
            q1.delete();
        end else begin
            if (b0.o_write_ready && b0.i_write_valid) ref0[b0.i_write_pointer] = b0.i_write_data;
            if (b0.o_read_ready && b0.i_read_valid) q0.push_back('{ref0[b0.i_read_pointer], cyc});
            if (b0.o_response_valid && b0.i_response_ready) begin
                resp0++;
                n_checks++;
                if (q0.size() == 0) begin
                    n_errors++;
                    $display("[TB] FAIL resp0_unexpected: got data %h, required no response", b0.o_response_data);
                end else begin
                    e = q0.pop_front();
                    lat0 = cyc - e.grant_cycle;
                    if (b0.o_response_data !== e.data) begin
                        n_errors++;
                        $display("[TB] FAIL resp0_data: got %h, required %h", b0.o_response_data, e.data);
                    end
                end
            end
            if (b1.o_write_ready && b1.i_write_valid) ref1[b1.i_write_pointer] = b1.i_write_data;
            if (b1.o_read_ready && b1.i_read_valid) q1.push_back('{ref1[b1.i_read_pointer], cyc});
            if (b1.o_response_valid && b1.i_response_ready) begin
                resp1++;
                n_checks++;
                if (q1.size() == 0) begin
                    n_errors++;
                    $display("[TB] FAIL resp1_unexpected: got data %h, required no response", b1.o_response_data);
                end else begin
                    e = q1.pop_front();
                    lat1 = cyc - e.grant_cycle;
                    if (b1.o_response_data !== e.data) begin
                        n_errors++;
                        $display("[TB] FAIL resp1_data: got %h, required %h", b1.o_response_data, e.data);
                    end
                end
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        drive_idle();
        for (int k = 0; k < 30 && (q0.size() != 0 || q1.size() != 0); k++) cycle();
        cycle();
        cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        b0.i_write_valid = 1'b1; b0.i_write_pointer = 6'd1; b0.i_read_valid = 1'b1;
        #1;
        n_checks++;
        if ({b0.o_write_ready, b0.o_read_ready, b0.o_sram_enable} !== 3'b000) begin
            n_errors++;
            $display("[TB] FAIL reset_grants: got %b, required 000", {b0.o_write_ready, b0.o_read_ready, b0.o_sram_enable});
        end
        cycle();
        cycle();
        rst = 1'b0;
        drive_idle();
        #1;
        n_checks++;
        if (b0.o_response_valid !== 1'b0) begin
            n_errors++; $display("[TB] FAIL reset_response_valid: got %b, required 0", b0.o_response_valid);
        end
        n_checks++;
        if (b0.o_response_data !== 32'h0) begin
            n_errors++; $display("[TB] FAIL reset_response_data: got %h, required 0", b0.o_response_data);
        end
        n_checks++;
        if ({b0.o_sram_write, b0.o_sram_pointer, b0.o_sram_write_data} !== 39'h0) begin
            n_errors++; $display("[TB] FAIL reset_sram_idle: got %h, required 0", {b0.o_sram_write, b0.o_sram_pointer, b0.o_sram_write_data});
        end
        n_checks++;
        if ({b1.o_response_valid, b1.o_response_data} !== 33'h0) begin
            n_errors++; $display("[TB] FAIL reset_lat3_response: got %h, required 0", {b1.o_response_valid, b1.o_response_data});
        end
        cycle();
    endtask

    task automatic test_write_read();
        int wc, rc;
        logic found;
        drive_idle();
        b0.i_write_valid = 1'b1; b0.i_write_pointer = 6'd3; b0.i_write_data = 32'hA5A5_0001;
        #1;
        n_checks++;
        if ({b0.o_write_ready, b0.o_sram_enable, b0.o_sram_write, b0.o_sram_pointer, b0.o_sram_write_data} !== {3'b111, 6'd3, 32'hA5A5_0001}) begin
            n_errors++;
            $display("[TB] FAIL wr_sram_write: got %h, required %h",
                     {b0.o_write_ready, b0.o_sram_enable, b0.o_sram_write, b0.o_sram_pointer, b0.o_sram_write_data},
                     {3'b111, 6'd3, 32'hA5A5_0001});
        end
        wc = cyc;
        cycle();
        b0.i_write_valid = 1'b0; b0.i_write_data = '0;
        b0.i_read_valid = 1'b1; b0.i_read_pointer = 6'd3;
        #1;
        n_checks++;
        if ({b0.o_read_ready, b0.o_sram_enable, b0.o_sram_write, b0.o_sram_pointer} !== {3'b110, 6'd3}) begin
            n_errors++;
            $display("[TB] FAIL wr_sram_read: got %h, required %h", {b0.o_read_ready, b0.o_sram_enable, b0.o_sram_write, b0.o_sram_pointer}, {3'b110, 6'd3});
        end
        cycle();
        drive_idle();
        found = 1'b0;
        rc = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            #1;
            if (b0.o_response_valid) begin
                found = 1'b1;
                rc = cyc;
                n_checks++;
                if (b0.o_response_data !== 32'hA5A5_0001) begin
                    n_errors++; $display("[TB] FAIL wr_data: got %h, required a5a50001", b0.o_response_data);
                end
            end
            cycle();
        end
        n_checks++;
        if (!found || (rc - wc) !== 3) begin
            n_errors++; $display("[TB] FAIL wr_latency: got found=%0b cycles=%0d, required found=1 cycles=3", found, rc - wc);
        end
        drain();
    endtask

    task automatic test_contention();
        rst = 1'b1;
        drive_idle();
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b0.i_write_valid = 1'b1; b0.i_write_pointer = 6'(40 + i); b0.i_write_data = $urandom;
            b0.i_read_valid  = 1'b1; b0.i_read_pointer  = 6'd3;
            #1;
            n_checks++;
            if ({b0.o_write_ready, b0.o_read_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_errors++;
                $display("[TB] FAIL contention_grant[%0d]: got wr/rd %b, required %b", i,
                         {b0.o_write_ready, b0.o_read_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
            end
            cycle();
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int base;
        drive_idle();
        for (int i = 0; i < 16; i++) begin
            b0.i_write_valid = 1'b1; b0.i_write_pointer = 6'(i); b0.i_write_data = 32'h1000_0000 + 32'(i) * 32'h111;
            cycle();
        end
        drive_idle();
        base = resp0;
        for (int i = 0; i < 16; i++) begin
            b0.i_read_valid = 1'b1; b0.i_read_pointer = 6'(i);
            #1;
            n_checks++;
            if (b0.o_read_ready !== 1'b1) begin
                n_errors++; $display("[TB] FAIL b2b_read_ready[%0d]: got %b, required 1", i, b0.o_read_ready);
            end
            cycle();
        end
        drain();
        n_checks++;
        if (resp0 - base !== 16) begin
            n_errors++; $display("[TB] FAIL b2b_count: got %0d responses, required 16", resp0 - base);
        end
        n_checks++;
        if (lat0 !== 2) begin
            n_errors++; $display("[TB] FAIL b2b_latency: got %0d, required 2", lat0);
        end
    endtask

    task automatic test_backpressure();
        int base;
        drive_idle();
        b0.i_response_ready = 1'b0;
        b0.i_read_valid = 1'b1; b0.i_read_pointer = 6'd5;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_checks++;
            if (b0.o_read_ready !== (i < 3)) begin
                n_errors++; $display("[TB] FAIL bp_read_ready[%0d]: got %b, required %b", i, b0.o_read_ready, (i < 3));
            end
            cycle();
        end
        for (int i = 0; i < 2; i++) begin
            b0.i_write_valid = 1'b1; b0.i_write_pointer = 6'(20 + i); b0.i_write_data = 32'h2000_0000 + 32'(i);
            #1;
            n_checks++;
            if ({b0.o_write_ready, b0.o_read_ready} !== 2'b10) begin
                n_errors++; $display("[TB] FAIL bp_write_proceeds[%0d]: got wr/rd %b, required 10", i, {b0.o_write_ready, b0.o_read_ready});
            end
            cycle();
        end
        b0.i_write_valid = 1'b0;
        b0.i_response_ready = 1'b1;
        base = resp0;
        #1;
        n_checks++;
        if ({b0.o_response_valid, b0.o_read_ready} !== 2'b10) begin
            n_errors++; $display("[TB] FAIL bp_release: got valid/rd %b, required 10", {b0.o_response_valid, b0.o_read_ready});
        end
        cycle();
        #1;
        n_checks++;
        if (b0.o_read_ready !== 1'b1) begin
            n_errors++; $display("[TB] FAIL bp_resume: got %b, required 1", b0.o_read_ready);
        end
        cycle();
        drain();
        n_checks++;
        if (resp0 - base !== 4) begin
            n_errors++; $display("[TB] FAIL bp_drain_count: got %0d responses, required 4", resp0 - base);
        end
    endtask

    task automatic test_reset_midflight();
        int stale;
        drive_idle();
        b0.i_response_ready = 1'b0;
        b0.i_write_valid = 1'b1; b0.i_write_pointer = 6'd7; b0.i_write_data = 32'h7777_0007;
        b0.i_read_valid  = 1'b1; b0.i_read_pointer  = 6'd6;
        #1;
        n_checks++;
        if ({b0.o_write_ready, b0.o_read_ready} !== 2'b10) begin
            n_errors++; $display("[TB] FAIL mid_first_grant: got wr/rd %b, required 10", {b0.o_write_ready, b0.o_read_ready});
        end
        cycle();
        b0.i_write_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (b0.o_read_ready !== 1'b1) begin
                n_errors++; $display("[TB] FAIL mid_read_ready[%0d]: got %b, required 1", i, b0.o_read_ready);
            end
            cycle();
        end
        b0.i_read_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if (b0.o_response_valid !== 1'b1) begin
            n_errors++; $display("[TB] FAIL mid_buffered: got %b, required 1", b0.o_response_valid);
        end
        cycle();
        rst = 1'b0;
        b0.i_response_ready = 1'b1;
        #1;
        n_checks++;
        if (b0.o_response_valid !== 1'b0) begin
            n_errors++; $display("[TB] FAIL mid_valid_after_reset: got %b, required 0", b0.o_response_valid);
        end
        stale = 0;
        for (int k = 0; k < 6; k++) begin
            if (b0.o_response_valid !== 1'b0) stale++;
            cycle();
        end
        n_checks++;
        if (stale !== 0) begin
            n_errors++; $display("[TB] FAIL mid_stale: got %0d stale cycles, required 0", stale);
        end
        b0.i_write_valid = 1'b1; b0.i_write_pointer = 6'd8; b0.i_write_data = 32'h8888_0008;
        b0.i_read_valid  = 1'b1; b0.i_read_pointer  = 6'd6;
        #1;
        n_checks++;
        if ({b0.o_write_ready, b0.o_read_ready} !== 2'b10) begin
            n_errors++; $display("[TB] FAIL mid_priority: got wr/rd %b, required 10", {b0.o_write_ready, b0.o_read_ready});
        end
        cycle();
        drain();
    endtask

    task automatic test_latency3();
        int base;
        drive_idle();
        for (int i = 0; i < 8; i++) begin
            b1.i_write_valid = 1'b1; b1.i_write_pointer = 6'(i); b1.i_write_data = 32'hC0DE_0000 + 32'(i);
            cycle();
        end
        b1.i_write_valid = 1'b0;
        base = resp1;
        for (int i = 0; i < 8; i++) begin
            b1.i_read_valid = 1'b1; b1.i_read_pointer = 6'(i);
            #1;
            n_checks++;
            if (b1.o_read_ready !== 1'b1) begin
                n_errors++; $display("[TB] FAIL lat3_read_ready[%0d]: got %b, required 1", i, b1.o_read_ready);
            end
            cycle();
        end
        drain();
        n_checks++;
        if (resp1 - base !== 8) begin
            n_errors++; $display("[TB] FAIL lat3_count: got %0d responses, required 8", resp1 - base);
        end
        n_checks++;
        if (lat1 !== 4) begin
            n_errors++; $display("[TB] FAIL lat3_latency: got %0d, required 4", lat1);
        end
    endtask

    initial begin
        drive_idle();
        $display("[TB] starting");
        test_reset();
        test_write_read();
        test_contention();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_latency3();
        n_checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_errors++; $display("[TB] FAIL scoreboard_empty: got %0d/%0d pending, required 0/0", q0.size(), q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
